mcu_regfile: RTL and testbench
==============================

Name: mcu_regfile

Overview:
- Integer register file that consumes the write-back stage's output: `wbck_o_rf_ena`, `wbck_o_rf_wdat` and `wbck_o_rf_rdidx`.
- Serves two combinational read ports to the decoder/ALU, with same-cycle write-to-read bypass.
- Holds a per-register busy scoreboard. Dispatch of a multi-cycle instruction sets its rd busy bit; write-back clears it.
- The dispatch stage uses the busy outputs to stall RAW/WAW hazards. Lives between wbck and the decode/dispatch logic.

Parameters:
- XLEN, 32, data width (from mcu_defines).
- RFIDX_WIDTH, 5, register index width (from mcu_defines).
- RF_NUM, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wbck_o_rf_ena  in  1  write enable from wbck.
- wbck_o_rf_wdat  in  XLEN  write data from wbck.
- wbck_o_rf_rdidx  in  RFIDX_WIDTH  write index from wbck.
- rf_rs1_idx  in  RFIDX_WIDTH  read port 1 index.
- rf_rs2_idx  in  RFIDX_WIDTH  read port 2 index.
- rf_rs1_dat  out  XLEN  read port 1 data.
- rf_rs2_dat  out  XLEN  read port 2 data.
- disp_set_ena  in  1  a multi-cycle instruction with rd is dispatched this cycle.
- disp_set_idx  in  RFIDX_WIDTH  rd of that instruction.
- disp_rd_idx  in  RFIDX_WIDTH  rd of the instruction being decoded (WAW check).
- cmt_flush  in  1  irq/excp flush from commit; clears the whole scoreboard.
- rf_rs1_busy  out  1  rs1 has a write pending.
- rf_rs2_busy  out  1  rs2 has a write pending.
- rf_rd_busy  out  1  disp_rd_idx has a write pending.
- rf_x1_dat  out  XLEN  x1 (ra) direct tap for the IFU return-address path; no bypass.

Behaviour:
- Reset: rst=1 at a clock edge clears all 31 registers to 0 and all busy bits to 0.
  - Every output is 0 in the cycle after reset is sampled.
  - Reset overrides a concurrent write, set or flush.
  - Reset asserted mid-operation discards pending busy state.
- Write: on the edge where `wbck_o_rf_ena`=1 and rdidx!=0, reg[rdidx] <= wdat. A write to x0 is dropped.
- Write latency: 1 cycle to the array; 0 cycles to the read ports via bypass.
- Read, combinational:
  - idx==0 → 0.
  - else if `wbck_o_rf_ena` & (rdidx==idx) → `wbck_o_rf_wdat` (bypass).
  - else → reg[idx].
  - Both ports are independent; both may bypass from the same write.
- Scoreboard: busy[31:1], busy[0] constant 0. Next-state priority, highest first:
  1. rst: all 0.
  2. cmt_flush: all 0, including a concurrent disp_set.
  3. disp_set_ena & idx!=0: busy[idx] <= 1. Wins over a same-cycle write-back clear of the same idx, because the new producer owns rd.
  4. `wbck_o_rf_ena` & rdidx!=0: busy[rdidx] <= 0.
- Set and clear on different indices in the same cycle both take effect.
- Busy outputs, combinational: rs1_busy = busy[rs1_idx] & ~(`wbck_o_rf_ena` & rdidx==rs1_idx). rs2_busy and rd_busy are formed the same way.
  - The current-cycle write-back hides the bit, so dispatch can proceed in the same cycle as the bypass.
  - busy[0] is never reported.
- A single-cycle instruction never sets busy; its write-back simply writes, and clearing an already-clear bit is harmless.
- Setting an already-busy idx (WAW) is legal here; dispatch must stall on rf_rd_busy. The RF does not count outstanding writes.

Decomposition:
- Shared package (mcu_defines): XLEN, RFIDX_WIDTH, RF_NUM, and the x0 index constant.
- One sub-module is natural: mcu_rf_scobd, holding the busy vector, set/clear/flush priority and the three busy lookups.
- The data array and bypass muxes stay in mcu_regfile.

Test Plan:
- Reset: preload x5=0xDEADBEEF, then assert rst for 1 cycle → rf_rs1_dat for idx 5 reads 0 next cycle; all busy outputs 0.
- Bypass: write x7=0x12345678 with rs1_idx=rs2_idx=7 in the same cycle → both ports show 0x12345678 that cycle and the next.
- x0: write x0=0xFFFFFFFF → a read of idx 0 returns 0. disp_set on idx 0 → rf_rs1_busy stays 0.
- Scoreboard life cycle, with rs1_idx=3:
  - set x3 → rs1_busy=1 from the next cycle.
  - write-back x3=0xA5 → rs1_busy=0 in the write-back cycle, with data 0xA5 bypassed.
  - next cycle: busy=0 and the array holds 0xA5.
- Simultaneous events:
  - set x9 and write-back x9 in the same cycle → busy[9]=1 afterwards.
  - set x9 together with cmt_flush → busy[9]=0 afterwards.
  - set x4 and write-back x6 in the same cycle → busy[4]=1, busy[6]=0.
- Flush: set x1, x2 and x31, then pulse cmt_flush → all busy outputs 0 next cycle; register data unchanged; rf_x1_dat is unaffected.

Source files
------------

// File: rtl/mcu_regfile_pkg.sv
// mcu_defines: shared core constants for the integer register file.
//   XLEN        - data width
//   RFIDX_WIDTH - register index width
//   RF_NUM      - architectural register count (x0 hardwired to zero)
//   X0_IDX      - index of the zero register
package mcu_defines;
   localparam int XLEN        = 32;
   localparam int RFIDX_WIDTH = 5;
   localparam int RF_NUM      = 32;

   localparam logic [RFIDX_WIDTH-1:0] X0_IDX = '0;

   typedef logic [XLEN-1:0]        xdat_t;
   typedef logic [RFIDX_WIDTH-1:0] rfidx_t;
endpackage

// File: rtl/mcu_regfile_scobd.sv
// mcu_rf_scobd: per-register busy scoreboard.
//   clk, rst      - core clock, synchronous active-high reset
//   set_ena/idx   - dispatch of a multi-cycle producer marks rd busy
//   clr_ena/idx   - write-back clears rd
//   flush         - commit flush clears every busy bit
//   rs1/rs2/rd_idx in, rs1/rs2/rd_busy out - lookups, hidden by a
//                   same-cycle write-back to the same index
import mcu_defines::*;

module mcu_rf_scobd (
   input  logic   clk,
   input  logic   rst,
   input  logic   set_ena,
   input  rfidx_t set_idx,
   input  logic   clr_ena,
   input  rfidx_t clr_idx,
   input  logic   flush,
   input  rfidx_t rs1_idx,
   input  rfidx_t rs2_idx,
   input  rfidx_t rd_idx,
   output logic   rs1_busy,
   output logic   rs2_busy,
   output logic   rd_busy
);

   logic [RF_NUM-1:0] busy;
   logic [RF_NUM-1:0] busy_nxt;

   // Clear first, then set: a new producer dispatched in the same cycle as
   // the old producer's write-back owns rd, so the set must win.
   always_comb begin
      busy_nxt = busy;
      if (clr_ena && (clr_idx != X0_IDX))
         busy_nxt[clr_idx] = 1'b0;
      if (set_ena && (set_idx != X0_IDX))
         busy_nxt[set_idx] = 1'b1;
      busy_nxt[X0_IDX] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         busy <= '0;
      else if (flush)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   // The write-back in flight is bypassed to the read ports, so its target
   // is no longer a hazard this cycle.
   always_comb begin
      rs1_busy = busy[rs1_idx] & ~(clr_ena & (clr_idx == rs1_idx));
      rs2_busy = busy[rs2_idx] & ~(clr_ena & (clr_idx == rs2_idx));
      rd_busy  = busy[rd_idx]  & ~(clr_ena & (clr_idx == rd_idx));
   end

endmodule

// File: rtl/mcu_regfile.sv
// mcu_regfile: integer register file with write-back bypass and busy
// scoreboard.
//   clk, rst                       - core clock, sync active-high reset
//   wbck_o_rf_ena/wdat/rdidx       - write port from write-back
//   rf_rs1_idx/rf_rs2_idx in       - read port indices
//   rf_rs1_dat/rf_rs2_dat out      - combinational read data (bypassed)
//   disp_set_ena/disp_set_idx      - multi-cycle producer dispatched
//   disp_rd_idx                    - rd of decoding instruction (WAW check)
//   cmt_flush                      - clears the scoreboard
//   rf_rs1_busy/rs2_busy/rd_busy   - pending-write indications
//   rf_x1_dat                      - raw x1 tap for the IFU, no bypass
import mcu_defines::*;

module mcu_regfile (
   input  logic   clk,
   input  logic   rst,
   input  logic   wbck_o_rf_ena,
   input  xdat_t  wbck_o_rf_wdat,
   input  rfidx_t wbck_o_rf_rdidx,
   input  rfidx_t rf_rs1_idx,
   input  rfidx_t rf_rs2_idx,
   output xdat_t  rf_rs1_dat,
   output xdat_t  rf_rs2_dat,
   input  logic   disp_set_ena,
   input  rfidx_t disp_set_idx,
   input  rfidx_t disp_rd_idx,
   input  logic   cmt_flush,
   output logic   rf_rs1_busy,
   output logic   rf_rs2_busy,
   output logic   rf_rd_busy,
   output xdat_t  rf_x1_dat
);

   xdat_t rf_mem [RF_NUM];

   // Entry 0 is held at zero so the array can be indexed directly; it
   // reduces to a constant.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RF_NUM; i++) begin
         if (rst || (i == int'(X0_IDX)))
            rf_mem[i] <= '0;
         else if (wbck_o_rf_ena && (wbck_o_rf_rdidx == rfidx_t'(i)))
            rf_mem[i] <= wbck_o_rf_wdat;
      end
   end

   function automatic xdat_t rd_port(input rfidx_t idx);
      if (idx == X0_IDX)
         return '0;
      else if (wbck_o_rf_ena && (wbck_o_rf_rdidx == idx))
         return wbck_o_rf_wdat;
      else
         return rf_mem[idx];
   endfunction

   always_comb begin
      rf_rs1_dat = rd_port(rf_rs1_idx);
      rf_rs2_dat = rd_port(rf_rs2_idx);
      rf_x1_dat  = rf_mem[1];
   end

   mcu_rf_scobd u_scobd (
      .clk      (clk),
      .rst      (rst),
      .set_ena  (disp_set_ena),
      .set_idx  (disp_set_idx),
      .clr_ena  (wbck_o_rf_ena),
      .clr_idx  (wbck_o_rf_rdidx),
      .flush    (cmt_flush),
      .rs1_idx  (rf_rs1_idx),
      .rs2_idx  (rf_rs2_idx),
      .rd_idx   (disp_rd_idx),
      .rs1_busy (rf_rs1_busy),
      .rs2_busy (rf_rs2_busy),
      .rd_busy  (rf_rd_busy)
   );

endmodule

// File: tb/tb_mcu_regfile.sv
module tb_mcu_regfile;
   logic        clk = 1'b0;
   logic        rst;
   logic        wbck_o_rf_ena;
   logic [31:0] wbck_o_rf_wdat;
   logic [4:0]  wbck_o_rf_rdidx;
   logic [4:0]  rf_rs1_idx;
   logic [4:0]  rf_rs2_idx;
   logic [31:0] rf_rs1_dat;
   logic [31:0] rf_rs2_dat;
   logic        disp_set_ena;
   logic [4:0]  disp_set_idx;
   logic [4:0]  disp_rd_idx;
   logic        cmt_flush;
   logic        rf_rs1_busy;
   logic        rf_rs2_busy;
   logic        rf_rd_busy;
   logic [31:0] rf_x1_dat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mcu_regfile dut (
      .clk             (clk),
      .rst             (rst),
      .wbck_o_rf_ena   (wbck_o_rf_ena),
      .wbck_o_rf_wdat  (wbck_o_rf_wdat),
      .wbck_o_rf_rdidx (wbck_o_rf_rdidx),
      .rf_rs1_idx      (rf_rs1_idx),
      .rf_rs2_idx      (rf_rs2_idx),
      .rf_rs1_dat      (rf_rs1_dat),
      .rf_rs2_dat      (rf_rs2_dat),
      .disp_set_ena    (disp_set_ena),
      .disp_set_idx    (disp_set_idx),
      .disp_rd_idx     (disp_rd_idx),
      .cmt_flush       (cmt_flush),
      .rf_rs1_busy     (rf_rs1_busy),
      .rf_rs2_busy     (rf_rs2_busy),
      .rf_rd_busy      (rf_rd_busy),
      .rf_x1_dat       (rf_x1_dat)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; wbck_o_rf_ena = 1'b0; wbck_o_rf_wdat = '0; wbck_o_rf_rdidx = '0;
      disp_set_ena = 1'b0; disp_set_idx = '0; cmt_flush = 1'b0;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] dat);
      wbck_o_rf_ena = 1'b1; wbck_o_rf_rdidx = idx; wbck_o_rf_wdat = dat;
   endtask

   task automatic setb(input logic [4:0] idx);
      disp_set_ena = 1'b1; disp_set_idx = idx;
   endtask

   initial begin
      idle();
      rf_rs1_idx = '0; rf_rs2_idx = '0; disp_rd_idx = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rf_rs1_idx = 5'd1; rf_rs2_idx = 5'd31; disp_rd_idx = 5'd7;
      #1;
      chk("rst_rs1_dat", rf_rs1_dat, 32'h0);
      chk("rst_rs2_dat", rf_rs2_dat, 32'h0);
      chk("rst_x1_dat", rf_x1_dat, 32'h0);
      chk("rst_busy", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h0);

      // preload x5, then reset clears it
      wr(5'd5, 32'hDEADBEEF);
      tick();
      idle();
      rf_rs1_idx = 5'd5;
      #1;
      chk("preload_x5", rf_rs1_dat, 32'hDEADBEEF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_clears_x5", rf_rs1_dat, 32'h0);
      chk("rst_busy_after", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h0);

      // reset overrides a concurrent write and set
      rst = 1'b1; wr(5'd5, 32'h11112222); setb(5'd5);
      tick();
      idle();
      disp_rd_idx = 5'd5;
      #1;
      chk("rst_over_write", rf_rs1_dat, 32'h0);
      chk("rst_over_set", {31'h0, rf_rd_busy}, 32'h0);

      // reset mid-operation discards pending busy
      setb(5'd10);
      tick();
      idle();
      disp_rd_idx = 5'd10;
      #1;
      chk("set_x10", {31'h0, rf_rd_busy}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_drops_x10", {31'h0, rf_rd_busy}, 32'h0);

      // bypass on both ports
      rf_rs1_idx = 5'd7; rf_rs2_idx = 5'd7;
      wr(5'd7, 32'h12345678);
      #1;
      chk("byp_rs1", rf_rs1_dat, 32'h12345678);
      chk("byp_rs2", rf_rs2_dat, 32'h12345678);
      tick();
      idle();
      #1;
      chk("arr_rs1_x7", rf_rs1_dat, 32'h12345678);
      chk("arr_rs2_x7", rf_rs2_dat, 32'h12345678);

      // x0 is hardwired
      rf_rs1_idx = 5'd0;
      wr(5'd0, 32'hFFFFFFFF);
      #1;
      chk("x0_byp", rf_rs1_dat, 32'h0);
      tick();
      idle();
      #1;
      chk("x0_arr", rf_rs1_dat, 32'h0);
      setb(5'd0);
      tick();
      idle();
      #1;
      chk("x0_busy", {31'h0, rf_rs1_busy}, 32'h0);

      // scoreboard life cycle on x3
      rf_rs1_idx = 5'd3; rf_rs2_idx = 5'd3; disp_rd_idx = 5'd3;
      setb(5'd3);
      #1;
      chk("x3_set_same_cyc", {31'h0, rf_rs1_busy}, 32'h0);
      tick();
      idle();
      #1;
      chk("x3_rs1_busy", {31'h0, rf_rs1_busy}, 32'h1);
      chk("x3_rs2_busy", {31'h0, rf_rs2_busy}, 32'h1);
      chk("x3_rd_busy", {31'h0, rf_rd_busy}, 32'h1);
      wr(5'd3, 32'h000000A5);
      #1;
      chk("x3_wb_hide", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h0);
      chk("x3_wb_byp", rf_rs1_dat, 32'h000000A5);
      tick();
      idle();
      #1;
      chk("x3_after_busy", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h0);
      chk("x3_after_dat", rf_rs2_dat, 32'h000000A5);

      // set beats same-index write-back clear
      rf_rs1_idx = 5'd9;
      setb(5'd9); wr(5'd9, 32'h99);
      tick();
      idle();
      #1;
      chk("x9_set_wins", {31'h0, rf_rs1_busy}, 32'h1);
      chk("x9_dat", rf_rs1_dat, 32'h99);

      // flush beats a concurrent set
      cmt_flush = 1'b1; setb(5'd9);
      tick();
      idle();
      #1;
      chk("x9_flush_wins", {31'h0, rf_rs1_busy}, 32'h0);

      // set and clear on different indices
      setb(5'd6);
      tick();
      setb(5'd4); wr(5'd6, 32'h66);
      tick();
      idle();
      rf_rs1_idx = 5'd4; rf_rs2_idx = 5'd6; disp_rd_idx = 5'd4;
      #1;
      chk("x4_set", {31'h0, rf_rs1_busy}, 32'h1);
      chk("x6_clr", {31'h0, rf_rs2_busy}, 32'h0);
      chk("x4_rd_busy", {31'h0, rf_rd_busy}, 32'h1);

      // flush clears busy, leaves data and the x1 tap
      wr(5'd1, 32'h00001000);
      tick();
      wr(5'd2, 32'h00002000);
      setb(5'd1);
      tick();
      idle();
      setb(5'd2);
      tick();
      setb(5'd31);
      tick();
      idle();
      rf_rs1_idx = 5'd1; rf_rs2_idx = 5'd2; disp_rd_idx = 5'd31;
      #1;
      chk("pre_flush_busy", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h7);
      cmt_flush = 1'b1;
      tick();
      idle();
      #1;
      chk("flush_busy", {29'h0, rf_rs1_busy, rf_rs2_busy, rf_rd_busy}, 32'h0);
      chk("flush_x1", rf_rs1_dat, 32'h00001000);
      chk("flush_x2", rf_rs2_dat, 32'h00002000);
      chk("flush_x1_tap", rf_x1_dat, 32'h00001000);

      // x1 tap is not bypassed
      wr(5'd1, 32'h00001111);
      #1;
      chk("x1_tap_nobyp", rf_x1_dat, 32'h00001000);
      chk("x1_port_byp", rf_rs1_dat, 32'h00001111);
      tick();
      idle();
      #1;
      chk("x1_tap_upd", rf_x1_dat, 32'h00001111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
